// File: rtl/req_responder_if.sv
// Request/acknowledge bundle between a requester and a req_responder.
// The requester drives req, req_key and hold. The responder drives ack.
interface req_responder_if;
   logic       req;
   logic [3:0] req_key;
   logic       hold;
   logic       ack;

   modport master (
      output req,
      output req_key,
      output hold,
      input  ack
   );

   modport slave (
      input  req,
      input  req_key,
      input  hold,
      output ack
   );
endinterface

// File: rtl/req_responder.sv
// Responder side of a single-outstanding req/ack key handshake.
// Acks after LATENCY wait cycles and tracks the mod-16 key sequence plus error status.
module req_responder #(
   parameter int unsigned LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   req_responder_if.slave     bus,
   output logic               busy,
   output logic [3:0]         exp_key,
   output logic [15:0]        done_count,
   output logic [7:0]         mismatch_count,
   output logic               proto_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   localparam int unsigned LAT_M1_I = (LATENCY > 0) ? LATENCY - 1 : 0;
   localparam logic [3:0]  LAT_M1   = LAT_M1_I[3:0];

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [3:0] key_inc(input logic [3:0] k);
      return k + 4'd1;
   endfunction

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] key_q;
   logic [3:0] cmp_key;
   logic       load_key;
   logic       set_err;
   logic       enter_ack;
   logic       ack_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      load_key = 1'b0;
      set_err  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req && !bus.hold) begin
               load_key = 1'b1;
               cnt_d    = LAT_M1;
               state_d  = (LATENCY == 0) ? S_ACK : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!bus.req) begin
               set_err = 1'b1;
               state_d = S_IDLE;
            end else if (bus.hold) begin
               state_d = S_WAIT;
            end else if (cnt_q == 4'd0) begin
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ACK always returns to IDLE, so a next state of ACK means entry this edge.
   // With zero latency the key is compared straight from the bus.
   assign enter_ack = (state_d == S_ACK);
   assign cmp_key   = (state_q == S_IDLE) ? bus.req_key : key_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         ack_q          <= 1'b0;
         proto_err      <= 1'b0;
         exp_key        <= 4'd0;
         done_count     <= 16'd0;
         mismatch_count <= 8'd0;
      end else begin
         state_q <= state_d;
         ack_q   <= enter_ack;
         if (set_err) begin
            proto_err <= 1'b1;
         end
         if (enter_ack) begin
            done_count <= done_count + 16'd1;
            if (cmp_key == exp_key) begin
               exp_key <= key_inc(exp_key);
            end else begin
               mismatch_count <= sat_inc8(mismatch_count);
               exp_key        <= key_inc(cmp_key);
            end
         end
      end
   end

   // Datapath registers carry no reset; they are only read after a fresh capture.
   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
      if (load_key) begin
         key_q <= bus.req_key;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign bus.ack = ack_q;

   a_ack_single: assert property (@(posedge clk) disable iff (!rst) ack_q |=> !ack_q);
   a_ack_busy:   assert property (@(posedge clk) disable iff (!rst) ack_q |-> busy);

endmodule

// File: tb/tb_req_responder.sv
// Bench for req_responder: directed handshake scenarios then randomized traffic,
// checked against a transaction-level model for LATENCY=2 and LATENCY=0 instances.
module tb_req_responder;

   logic clk;
   logic rst;

   logic       req_v[2];
   logic [3:0] key_v[2];
   logic       hold_v[2];

   logic        busy_a, busy_b, err_a, err_b;
   logic [3:0]  exp_a, exp_b;
   logic [15:0] done_a, done_b;
   logic [7:0]  mis_a, mis_b;

   req_responder_if ifa ();
   req_responder_if ifb ();

   assign ifa.req     = req_v[0];
   assign ifa.req_key = key_v[0];
   assign ifa.hold    = hold_v[0];
   assign ifb.req     = req_v[1];
   assign ifb.req_key = key_v[1];
   assign ifb.hold    = hold_v[1];

   req_responder #(.LATENCY(2)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa), .busy(busy_a), .exp_key(exp_a),
      .done_count(done_a), .mismatch_count(mis_a), .proto_err(err_a)
   );

   req_responder #(.LATENCY(0)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb), .busy(busy_b), .exp_key(exp_b),
      .done_count(done_b), .mismatch_count(mis_b), .proto_err(err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state, one entry per instance
   int lat[2] = '{2, 0};
   bit m_busy[2], m_ack[2], m_err[2];
   int m_rem[2], m_key[2], m_exp[2], m_done[2], m_mis[2];
   int next_key[2];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 0; m_ack[i] = 0; m_err[i] = 0; m_rem[i] = 0;
         m_key[i]  = 0; m_exp[i] = 0; m_done[i] = 0; m_mis[i] = 0;
      end
   endtask

   task automatic model_complete(input int i);
      m_ack[i]  = 1;
      m_done[i] = (m_done[i] + 1) % 65536;
      if (m_key[i] == m_exp[i]) begin
         m_exp[i] = (m_exp[i] + 1) % 16;
      end else begin
         if (m_mis[i] < 255) m_mis[i] = m_mis[i] + 1;
         m_exp[i] = (m_key[i] + 1) % 16;
      end
   endtask

   // m_rem counts the un-stalled wait cycles still owed before the ack cycle
   task automatic model_step(input int i, input bit r, input int k, input bit h);
      if (m_ack[i]) begin
         m_ack[i]  = 0;
         m_busy[i] = 0;
      end else if (!m_busy[i]) begin
         if (r && !h) begin
            m_key[i]  = k;
            m_busy[i] = 1;
            if (lat[i] == 0) model_complete(i);
            else             m_rem[i] = lat[i];
         end
      end else if (!r) begin
         m_err[i]  = 1;
         m_busy[i] = 0;
      end else if (!h) begin
         m_rem[i] = m_rem[i] - 1;
         if (m_rem[i] == 0) model_complete(i);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("ack%0d", i),  (i == 0) ? 32'(ifa.ack) : 32'(ifb.ack), 32'(m_ack[i]));
         check_eq($sformatf("busy%0d", i), (i == 0) ? 32'(busy_a)  : 32'(busy_b),  32'(m_busy[i]));
         check_eq($sformatf("exp%0d", i),  (i == 0) ? 32'(exp_a)   : 32'(exp_b),   32'(m_exp[i]));
         check_eq($sformatf("done%0d", i), (i == 0) ? 32'(done_a)  : 32'(done_b),  32'(m_done[i]));
         check_eq($sformatf("mis%0d", i),  (i == 0) ? 32'(mis_a)   : 32'(mis_b),   32'(m_mis[i]));
         check_eq($sformatf("err%0d", i),  (i == 0) ? 32'(err_a)   : 32'(err_b),   32'(m_err[i]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 2; i++) model_step(i, req_v[i], int'(key_v[i]), hold_v[i]);
      end
      #1;
      check_all();
   endtask

   // Assert reset between edges, check the immediate effect, release mid-cycle
   task automatic async_reset();
      #2 rst = 1'b0;
      model_reset();
      #1;
      check_all();
      check_eq("rst_busy_a", 32'(busy_a), 32'd0);
      check_eq("rst_ack_a",  32'(ifa.ack), 32'd0);
      check_eq("rst_done_a", 32'(done_a), 32'd0);
      step();
      #2 rst = 1'b1;
   endtask

   task automatic wait_ack(input int i, input int max, output int edges);
      edges = -1;
      for (int n = 1; n <= max; n++) begin
         step();
         if (((i == 0) ? ifa.ack : ifb.ack) === 1'b1) begin
            edges = n;
            break;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, e2;
      int saved_done, saved_exp;

      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_v[i] = 1'b0; key_v[i] = 4'd0; hold_v[i] = 1'b0; next_key[i] = 0;
      end
      model_reset();
      @(posedge clk);
      #1;
      async_reset();

      // Basic handshake, key 0 from cycle 0
      req_v[0] = 1'b1; key_v[0] = 4'd0;
      wait_ack(0, 10, e);
      check_eq("basic_ack_cycle", 32'(e), 32'd3);
      req_v[0] = 1'b0;
      step();
      check_eq("basic_done", 32'(done_a), 32'd1);
      check_eq("basic_exp",  32'(exp_a),  32'd1);
      check_eq("basic_mis",  32'(mis_a),  32'd0);

      // Sequence wrap 0..15,0
      async_reset();
      for (int k = 0; k < 17; k++) begin
         req_v[0] = 1'b1; key_v[0] = 4'(k % 16);
         wait_ack(0, 20, e);
         check_eq("wrap_gap", 32'(e), (k == 0) ? 32'd3 : 32'd4);
      end
      req_v[0] = 1'b0;
      step();
      check_eq("wrap_done", 32'(done_a), 32'd17);
      check_eq("wrap_exp",  32'(exp_a),  32'd1);
      check_eq("wrap_mis",  32'(mis_a),  32'd0);

      // Mismatch then saturation
      req_v[0] = 1'b1; key_v[0] = 4'd5;
      wait_ack(0, 10, e);
      check_eq("mis_ack_cycle", 32'(e), 32'd3);
      check_eq("mis_count1", 32'(mis_a), 32'd1);
      check_eq("mis_exp6",   32'(exp_a), 32'd6);
      for (int k = 0; k < 300; k++) begin
         key_v[0] = 4'((m_exp[0] + 3) % 16);
         wait_ack(0, 10, e);
         if (e != 4) check_eq("sat_gap", 32'(e), 32'd4);
      end
      req_v[0] = 1'b0;
      step();
      check_eq("mis_sat", 32'(mis_a), 32'd255);

      // Protocol violation: req dropped in first WAIT cycle
      saved_done = int'(done_a);
      saved_exp  = int'(exp_a);
      req_v[0] = 1'b1; key_v[0] = exp_a;
      step();
      req_v[0] = 1'b0;
      step();
      check_eq("proto_busy", 32'(busy_a), 32'd0);
      check_eq("proto_err",  32'(err_a),  32'd1);
      check_eq("proto_done", 32'(done_a), 32'(saved_done));
      check_eq("proto_exp",  32'(exp_a),  32'(saved_exp));
      repeat (3) step();
      check_eq("proto_sticky", 32'(err_a), 32'd1);

      // Stall in WAIT, then stall in IDLE
      async_reset();
      req_v[0] = 1'b1; key_v[0] = 4'd0;
      step();
      hold_v[0] = 1'b1;
      repeat (3) step();
      hold_v[0] = 1'b0;
      wait_ack(0, 10, e2);
      check_eq("stall_ack_cycle", 32'(4 + e2), 32'd6);
      req_v[0] = 1'b0;
      step();
      hold_v[0] = 1'b1; req_v[0] = 1'b1; key_v[0] = 4'd1;
      for (int k = 0; k < 4; k++) begin
         step();
         check_eq("hold_idle_busy", 32'(busy_a), 32'd0);
      end
      hold_v[0] = 1'b0;
      step();
      check_eq("hold_release_busy", 32'(busy_a), 32'd1);
      wait_ack(0, 10, e);
      req_v[0] = 1'b0;
      step();

      // Reset asserted mid-WAIT loses the ack
      req_v[0] = 1'b1; key_v[0] = exp_a;
      step();
      step();
      req_v[0] = 1'b0;
      async_reset();
      check_eq("midwait_err", 32'(err_a), 32'd0);
      check_eq("midwait_exp", 32'(exp_a), 32'd0);
      check_eq("midwait_mis", 32'(mis_a), 32'd0);

      // Zero latency instance
      req_v[1] = 1'b1; key_v[1] = 4'd0;
      wait_ack(1, 10, e);
      check_eq("lat0_ack_cycle", 32'(e), 32'd1);
      req_v[1] = 1'b0;
      step();
      check_eq("lat0_done", 32'(done_b), 32'd1);
      check_eq("lat0_exp",  32'(exp_b),  32'd1);

      // Randomized traffic on both instances
      for (int i = 0; i < 2; i++) next_key[i] = m_exp[i];
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (m_ack[i]) begin
               req_v[i] = ($urandom_range(0, 3) != 0);
               key_v[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'(next_key[i]);
               next_key[i] = (int'(key_v[i]) + 1) % 16;
            end else if (req_v[i]) begin
               if ($urandom_range(0, 63) == 0) req_v[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               req_v[i] = 1'b1;
               key_v[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'(next_key[i]);
               next_key[i] = (int'(key_v[i]) + 1) % 16;
            end
            hold_v[i] = ($urandom_range(0, 3) == 0);
         end
         if ($urandom_range(0, 399) == 0) begin
            async_reset();
            for (int i = 0; i < 2; i++) next_key[i] = 0;
         end else begin
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/req_responder.md
# req_responder

Responder end of the single-outstanding req/ack key handshake. It accepts a request carrying a 4-bit sequence key and returns a one-cycle `ack` after a fixed, parameterised service latency. It checks each key against the expected mod-16 sequence and keeps completion, mismatch and protocol-error status. It sits opposite a requester that holds `req` and `req_key` until acked, then presents the next key.

## Interface
- `LATENCY`, default 2: wait cycles between accepting a request and asserting `ack`; legal range 0..15.
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req` input 1: request valid; held high by the requester until acked.
- `req_key` input 4: request key; stable while `req` is high.
- `hold` input 1: stall; blocks acceptance in IDLE and freezes the wait counter in WAIT.
- `ack` output 1: registered one-cycle acknowledge.
- `busy` output 1: high whenever the state is not IDLE.
- `exp_key` output 4: next expected key.
- `done_count` output 16: completed handshakes; wraps at 2^16.
- `mismatch_count` output 8: key mismatches; saturates at 255.
- `proto_err` output 1: sticky flag, set when `req` is withdrawn before `ack`.

## Operation
- States: IDLE, WAIT, ACK.
- IDLE, when `req`=1 and `hold`=0:
  - Capture `req_key` into `key_q`.
  - Go to ACK if `LATENCY`=0; otherwise go to WAIT and load `cnt` = `LATENCY`-1.
- IDLE, otherwise: stay.
- WAIT, when `req`=0: set `proto_err`, return to IDLE. No ack is issued and no counter or `exp_key` changes.
- WAIT, else when `hold`=1: stay, `cnt` unchanged.
- WAIT, else when `cnt`=0: go to ACK.
- WAIT, else: `cnt` decrements by 1.
- ACK: `ack`=1 for exactly this cycle, then IDLE unconditionally. `hold` and `req` are ignored here.
- On entering ACK (same edge):
  - `done_count` +1, wrapping.
  - If `key_q` equals `exp_key`: `exp_key` becomes `exp_key`+1 mod 16.
  - If they differ: `mismatch_count` +1 (holding at 255), and `exp_key` resyncs to `key_q`+1 mod 16.
- `proto_err` clears only on reset.
- `cnt` is a 4-bit register. All key arithmetic is 4-bit modulo 16.

## Timing
- Reset (`rst`=0) acts immediately, without waiting for a clock edge:
  - State IDLE.
  - `ack`, `busy`, `proto_err` = 0.
  - `exp_key` = 0, `done_count` = 0, `mismatch_count` = 0.
- Latency: request accepted at the end of cycle 0 gives `ack` high in cycle `LATENCY`+1, plus one cycle per WAIT cycle with `hold`=1.
- Throughput: one handshake per `LATENCY`+2 cycles when `req` stays high.
- The IDLE cycle after ACK samples the requester's next key. The requester updates its key on the ack edge.
- `req` high during the ACK cycle belongs to the request being acked and is not a new request.
- `hold` rising in the same cycle as `req` in IDLE: the request is not accepted that cycle.
- Reset released mid-stream: the first accepted key is checked against 0.
- Reset asserted in WAIT or ACK: the ack is lost and no counters update.

## Test plan
Use `LATENCY`=2 unless noted.
- **Basic handshake:** reset, then `req`=1, `req_key`=0 from cycle 0 → `ack` high only in cycle 3, `busy` high in cycles 1-3, `done_count`=1, `exp_key`=1, `mismatch_count`=0.
- **Sequence wrap:** `req` held high with keys 0,1,…,15,0 advanced on each ack → 17 acks spaced 4 cycles apart, `exp_key` goes 15→0→1, `mismatch_count`=0, `done_count`=17.
- **Mismatch and saturation:** with `exp_key`=1, present key 5 → ack in the usual cycle, `mismatch_count`=1, `exp_key`=6. Next, 300 consecutive wrong keys → `mismatch_count` stays at 255.
- **Protocol violation:** drop `req` in the first WAIT cycle → no ack, `proto_err`=1 and stays 1, `done_count` and `exp_key` unchanged, `busy` low the next cycle.
- **Stall:** `hold`=1 for 3 cycles during WAIT → ack in cycle 6 instead of 3. `hold`=1 in IDLE with `req`=1 → no acceptance until `hold` falls.
- **Reset and zero latency:** assert `rst` low mid-WAIT between clock edges → all outputs 0 at once, no ack. Rerun scenario 1 with `LATENCY`=0 → ack in cycle 1.
